regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
Command-driven initiator for the 8x8 CPU register file. It accepts read, write and dump commands over a valid/ready command channel and drives the register file's address, write-enable and write-data pins. Read data returns on a valid/ready response channel. It sits between the debug/loader front end and the register file. It is the only driver of the register-file control pins while instantiated.

Parameters:
DATA_WIDTH, 8, register width
ADDR_WIDTH, 3, register index width
NUM_REGS, 8, register count; dump sweeps 0..NUM_REGS-1

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 READ, 01 WRITE, 10 DUMP, 11 reserved
cmd_addr_a  in  ADDR_WIDTH  write target / read port-1 index
cmd_addr_b  in  ADDR_WIDTH  read port-2 index
cmd_wdata  in  DATA_WIDTH  write data
rf_write_enable  out  1  to register file write enable
rf_read_reg1  out  ADDR_WIDTH  to register file port-1 index (also the write index)
rf_read_reg2  out  ADDR_WIDTH  to register file port-2 index
rf_write_data  out  DATA_WIDTH  to register file write data
rf_read_data1  in  DATA_WIDTH  combinational port-1 data
rf_read_data2  in  DATA_WIDTH  combinational port-2 data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_data_a  out  DATA_WIDTH  port-1 data
rsp_data_b  out  DATA_WIDTH  port-2 data
rsp_addr  out  ADDR_WIDTH  port-1 index of this response
rsp_last  out  1  final response of a READ or DUMP
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs 0: rf_write_enable, rf_read_reg1/2, rf_write_data, rsp_valid, rsp_data_a/b, rsp_addr, rsp_last and the dump index. Reset mid-operation aborts it immediately; no write is issued in the reset cycle and no response remains pending.
- States: IDLE, WRITE, READ, RESP, DUMP_RD, DUMP_RSP.
- cmd_ready = (state == IDLE). It is combinational from the state register only, never from cmd_valid.
- IDLE accept with WRITE: latch addr_a into rf_read_reg1 and wdata into rf_write_data, then go to WRITE.
- WRITE: rf_write_enable=1 for exactly one cycle, so the register file updates at the end of this cycle. Then go to IDLE. Writes produce no response.
- IDLE accept with READ: latch addr_a into rf_read_reg1 and addr_b into rf_read_reg2, then go to READ.
- READ: at the clock edge, capture rf_read_data1/2 into rsp_data_a/b, set rsp_addr=rf_read_reg1, rsp_last=1, rsp_valid=1, then go to RESP.
- RESP: hold all rsp_* stable while rsp_valid & !rsp_ready. On the handshake, rsp_valid=0 and go to IDLE.
- IDLE accept with DUMP: index=0, rf_read_reg1=0, rf_read_reg2=0, then go to DUMP_RD.
- DUMP_RD: capture port-1 data into both rsp_data_a and rsp_data_b, set rsp_addr=index, rsp_last=(index==NUM_REGS-1), rsp_valid=1, then go to DUMP_RSP.
- DUMP_RSP, on handshake:
  - If last: go to IDLE.
  - Otherwise: index+1 into rf_read_reg1/2, then go to DUMP_RD.
- Reserved op 11: accepted (one handshake) and discarded; state stays IDLE with no side effects.
- Latency:
  - WRITE visible to a following READ: accept at cycle N, write at edge N+2, earliest next accept N+2.
  - READ: rsp_valid rises 2 cycles after accept.
  - DUMP: response k valid no earlier than 2 cycles after handshake k-1.
- rf_write_enable is asserted only in WRITE, never in any other state.
- rf_read_reg1/2 and rf_write_data hold their last value outside the states that update them.
- READ with addr_a == addr_b is legal; both data fields are equal.
- Back-pressure: rsp_ready low for any number of cycles stalls the state machine with no loss. cmd_ready stays 0 throughout.
- busy=1 in every state except IDLE.

Test Plan:
- Reset, then READ a=2 b=5 with the register file at power-up contents (reg[i]=i+1) -> rsp_valid 2 cycles after accept; data_a=03, data_b=06, addr=2, last=1.
- WRITE a=4 wdata=A5, then READ a=4 b=4 -> rf_write_enable high for exactly 1 cycle with rf_read_reg1=4 and rf_write_data=A5; READ returns A5/A5.
- DUMP with rsp_ready held high -> 8 responses with addr 0..7 and data 01..08; rsp_last only on addr 7; busy then drops; cmd_ready returns to 1.
- DUMP with rsp_ready low for 3 cycles on response 3 -> rsp_data_a=04 and addr=3 held stable; no response skipped or duplicated; cmd_ready stays 0.
- rst asserted in WRITE state and in DUMP_RSP at index 5 -> next cycle state IDLE, rsp_valid=0, rf_write_enable=0; the target register is unchanged.
- cmd_op=11 with cmd_valid=1 -> one handshake, no rf_write_enable, no rsp_valid; a following READ behaves normally.

Source files
------------

// File: rtl/regfile_access_ctrl_if.sv
// Bundles the command, response and register-file pins of the access controller.
// The controller takes the slave view; the front end and register file take the master view.
interface regfile_access_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr_a;
    logic [ADDR_WIDTH-1:0] cmd_addr_b;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rf_write_enable;
    logic [ADDR_WIDTH-1:0] rf_read_reg1;
    logic [ADDR_WIDTH-1:0] rf_read_reg2;
    logic [DATA_WIDTH-1:0] rf_write_data;
    logic [DATA_WIDTH-1:0] rf_read_data1;
    logic [DATA_WIDTH-1:0] rf_read_data2;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data_a;
    logic [DATA_WIDTH-1:0] rsp_data_b;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  rsp_last;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_wdata,
        input  rf_read_data1, rf_read_data2, rsp_ready,
        output cmd_ready, rf_write_enable, rf_read_reg1, rf_read_reg2, rf_write_data,
        output rsp_valid, rsp_data_a, rsp_data_b, rsp_addr, rsp_last
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_wdata,
        output rf_read_data1, rf_read_data2, rsp_ready,
        input  cmd_ready, rf_write_enable, rf_read_reg1, rf_read_reg2, rf_write_data,
        input  rsp_valid, rsp_data_a, rsp_data_b, rsp_addr, rsp_last
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for the CPU register file: executes READ, WRITE and DUMP
// commands on the register-file pins and returns read data on a valid/ready channel.
module regfile_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_access_ctrl_if.slave  bus,
    output logic                  busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_RESP, S_DUMP_RD, S_DUMP_RSP
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rr1_q, rr1_d, rr2_q, rr2_d, idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d;
    logic [DATA_WIDTH-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic [ADDR_WIDTH-1:0] idx_next;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr1_q       <= '0;
            rr2_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            rsp_addr_q  <= '0;
        end else begin
            rr1_q       <= rr1_d;
            rr2_q       <= rr2_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            rsp_addr_q  <= rsp_addr_d;
        end
    end

    assign idx_next = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        rr1_d       = rr1_q;
        rr2_d       = rr2_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_last_d  = rsp_last_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        rsp_addr_d  = rsp_addr_q;
        unique case (state_q)
            S_IDLE: begin
                // Reserved opcode falls through every branch: accepted, then dropped.
                if (bus.cmd_valid) begin
                    if (bus.cmd_op == OP_WRITE) begin
                        rr1_d   = bus.cmd_addr_a;
                        wdata_d = bus.cmd_wdata;
                        state_d = S_WRITE;
                    end else if (bus.cmd_op == OP_READ) begin
                        rr1_d   = bus.cmd_addr_a;
                        rr2_d   = bus.cmd_addr_b;
                        state_d = S_READ;
                    end else if (bus.cmd_op == OP_DUMP) begin
                        idx_d   = '0;
                        rr1_d   = '0;
                        rr2_d   = '0;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_READ: begin
                rsp_a_d     = bus.rf_read_data1;
                rsp_b_d     = bus.rf_read_data2;
                rsp_addr_d  = rr1_q;
                rsp_last_d  = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_DUMP_RD: begin
                rsp_a_d     = bus.rf_read_data1;
                rsp_b_d     = bus.rf_read_data1;
                rsp_addr_d  = idx_q;
                rsp_last_d  = (idx_q == LAST_IDX);
                rsp_valid_d = 1'b1;
                state_d     = S_DUMP_RSP;
            end
            S_DUMP_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_next;
                        rr1_d   = idx_next;
                        rr2_d   = idx_next;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write strobe is gated by rst so an aborted WRITE never reaches the register file.
    always_comb begin
        bus.cmd_ready       = (state_q == S_IDLE);
        bus.rf_write_enable = (state_q == S_WRITE) && !rst;
        busy                = (state_q != S_IDLE);
    end

    assign bus.rf_read_reg1  = rr1_q;
    assign bus.rf_read_reg2  = rr2_q;
    assign bus.rf_write_data = wdata_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data_a    = rsp_a_q;
    assign bus.rsp_data_b    = rsp_b_q;
    assign bus.rsp_addr      = rsp_addr_q;
    assign bus.rsp_last      = rsp_last_q;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a behavioural register file drives the read pins,
// and a plain array of expected register contents predicts every response.
module tb_regfile_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic rf_load = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [7:0] rf_mem [8];
    logic [7:0] model  [8];

    regfile_access_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    regfile_access_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'(i + 1);
        end else if (bus.rf_write_enable) begin
            rf_mem[bus.rf_read_reg1] <= bus.rf_write_data;
        end
    end
    assign bus.rf_read_data1 = rf_mem[bus.rf_read_reg1];
    assign bus.rf_read_data2 = rf_mem[bus.rf_read_reg2];

    task automatic send_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                            input logic [7:0] wd, output int acc_cyc);
        bus.cmd_op     = op;
        bus.cmd_addr_a = a;
        bus.cmd_addr_b = b;
        bus.cmd_wdata  = wd;
        bus.cmd_valid  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.cmd_ready === 1'b1) begin
                acc_cyc = cyc;
                @(posedge clk); #1;
                bus.cmd_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        $display("FAIL send_cmd: cmd_ready got %b required 1 within 40 cycles", bus.cmd_ready);
        $fatal(1, "command channel stuck");
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    // Waits for a response, optionally withholds rsp_ready for `stall` cycles, then consumes it.
    task automatic get_rsp(input int stall, output bit ok, output logic [7:0] da,
                           output logic [7:0] db, output logic [2:0] ad, output logic last,
                           output bit stable, output int rcyc);
        stable = 1'b1;
        wait_valid(ok);
        rcyc = cyc;
        da = bus.rsp_data_a;
        db = bus.rsp_data_b;
        ad = bus.rsp_addr;
        last = bus.rsp_last;
        if (!ok) return;
        if (stall > 0) begin
            bus.rsp_ready = 1'b0;
            repeat (stall) begin
                @(posedge clk); #1;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data_a !== da || bus.rsp_data_b !== db ||
                    bus.rsp_addr !== ad || bus.rsp_last !== last || bus.cmd_ready !== 1'b0)
                    stable = 1'b0;
            end
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rf_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (bus.rsp_valid !== 1'b0 || bus.rsp_last !== 1'b0) $display("FAIL reset rsp_valid/last: got %b/%b want 0/0", bus.rsp_valid, bus.rsp_last); else n_pass++;
        n_chk++; if (bus.rf_write_enable !== 1'b0) $display("FAIL reset rf_write_enable: got %b want 0", bus.rf_write_enable); else n_pass++;
        n_chk++; if ({bus.rf_read_reg1, bus.rf_read_reg2, bus.rf_write_data} !== 14'd0) $display("FAIL reset rf pins: got %h/%h/%h want 0/0/0", bus.rf_read_reg1, bus.rf_read_reg2, bus.rf_write_data); else n_pass++;
        n_chk++; if ({bus.rsp_data_a, bus.rsp_data_b, bus.rsp_addr} !== 19'd0) $display("FAIL reset rsp fields: got %h/%h/%h want 0/0/0", bus.rsp_data_a, bus.rsp_data_b, bus.rsp_addr); else n_pass++;
    endtask

    task automatic test_read_basic();
        int acc, rc; bit ok, st; logic [7:0] da, db; logic [2:0] ad; logic last;
        send_cmd(2'b00, 3'd2, 3'd5, 8'h00, acc);
        get_rsp(0, ok, da, db, ad, last, st, rc);
        n_chk++; if (!ok) $display("FAIL read_basic rsp_valid: got 0 want 1 within 20 cycles"); else n_pass++;
        n_chk++; if (rc - acc != 2) $display("FAIL read_basic latency: got %0d want 2", rc - acc); else n_pass++;
        n_chk++; if (da !== model[2] || db !== model[5]) $display("FAIL read_basic data: got %h/%h want %h/%h", da, db, model[2], model[5]); else n_pass++;
        n_chk++; if (ad !== 3'd2 || last !== 1'b1) $display("FAIL read_basic addr/last: got %0d/%b want 2/1", ad, last); else n_pass++;
    endtask

    task automatic test_dump(input int stall_idx, input int stall_len, input string tag);
        int acc, rc; bit ok, st; logic [7:0] da, db; logic [2:0] ad; logic last;
        send_cmd(2'b10, 3'd0, 3'd0, 8'h00, acc);
        for (int k = 0; k < 8; k++) begin
            get_rsp((k == stall_idx) ? stall_len : 0, ok, da, db, ad, last, st, rc);
            n_chk++; if (!ok || ad !== 3'(k)) $display("FAIL %s addr k=%0d: got %0d want %0d", tag, k, ad, k); else n_pass++;
            n_chk++; if (da !== model[k] || db !== model[k]) $display("FAIL %s data k=%0d: got %h/%h want %h", tag, k, da, db, model[k]); else n_pass++;
            n_chk++; if (last !== (k == 7)) $display("FAIL %s last k=%0d: got %b want %b", tag, k, last, (k == 7)); else n_pass++;
            if (k == stall_idx) begin
                n_chk++; if (!st) $display("FAIL %s stall k=%0d: got unstable/cmd_ready want held", tag, k); else n_pass++;
            end
        end
        n_chk++; if (busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) $display("FAIL %s end: got busy=%b ready=%b valid=%b want 0/1/0", tag, busy, bus.cmd_ready, bus.rsp_valid); else n_pass++;
    endtask

    task automatic test_write();
        int acc, rc, we_cnt; bit ok, st; logic [7:0] da, db; logic [2:0] ad; logic last;
        send_cmd(2'b01, 3'd4, 3'd0, 8'hA5, acc);
        model[4] = 8'hA5;
        n_chk++; if (bus.rf_write_enable !== 1'b1 || bus.rf_read_reg1 !== 3'd4 || bus.rf_write_data !== 8'hA5)
            $display("FAIL write pins: got we=%b reg1=%0d wd=%h want 1/4/a5", bus.rf_write_enable, bus.rf_read_reg1, bus.rf_write_data); else n_pass++;
        we_cnt = 1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.rf_write_enable === 1'b1) we_cnt++;
        end
        n_chk++; if (we_cnt != 1) $display("FAIL write we_cycles: got %0d want 1", we_cnt); else n_pass++;
        send_cmd(2'b00, 3'd4, 3'd4, 8'h00, acc);
        get_rsp(0, ok, da, db, ad, last, st, rc);
        n_chk++; if (!ok || da !== 8'hA5 || db !== 8'hA5) $display("FAIL write readback: got %h/%h want a5/a5", da, db); else n_pass++;
    endtask

    task automatic test_reserved();
        int acc, rc, hits; bit ok, st; logic [7:0] da, db; logic [2:0] ad; logic last;
        send_cmd(2'b11, 3'd3, 3'd1, 8'h5A, acc);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rf_write_enable !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) hits++;
            @(posedge clk); #1;
        end
        n_chk++; if (hits != 0) $display("FAIL reserved side_effects: got %0d cycles active want 0", hits); else n_pass++;
        send_cmd(2'b00, 3'd1, 3'd7, 8'h00, acc);
        get_rsp(0, ok, da, db, ad, last, st, rc);
        n_chk++; if (!ok || da !== model[1] || db !== model[7] || ad !== 3'd1) $display("FAIL reserved followup: got %h/%h@%0d want %h/%h@1", da, db, ad, model[1], model[7]); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int acc, rc; bit ok, st; logic [7:0] da, db; logic [2:0] ad; logic last;
        send_cmd(2'b01, 3'd6, 3'd0, 8'h3C, acc);
        rst = 1'b1;
        #1;
        n_chk++; if (bus.rf_write_enable !== 1'b0) $display("FAIL abort_write we_in_reset: got %b want 0", bus.rf_write_enable); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        n_chk++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rf_write_enable !== 1'b0) $display("FAIL abort_write state: got busy=%b valid=%b we=%b want 0/0/0", busy, bus.rsp_valid, bus.rf_write_enable); else n_pass++;
        send_cmd(2'b00, 3'd6, 3'd6, 8'h00, acc);
        get_rsp(0, ok, da, db, ad, last, st, rc);
        n_chk++; if (!ok || da !== model[6]) $display("FAIL abort_write target: got %h want %h", da, model[6]); else n_pass++;

        send_cmd(2'b10, 3'd0, 3'd0, 8'h00, acc);
        for (int k = 0; k < 5; k++) get_rsp(0, ok, da, db, ad, last, st, rc);
        wait_valid(ok);
        n_chk++; if (!ok || bus.rsp_addr !== 3'd5) $display("FAIL abort_dump reach: got addr %0d want 5", bus.rsp_addr); else n_pass++;
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        n_chk++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) $display("FAIL abort_dump state: got busy=%b valid=%b ready=%b want 0/0/1", busy, bus.rsp_valid, bus.cmd_ready); else n_pass++;
        ok = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        n_chk++; if (!ok) $display("FAIL abort_dump quiet: got activity after reset want none"); else n_pass++;
    endtask

    task automatic test_random();
        int acc, rc; bit ok, st; logic [7:0] da, db, wd; logic [2:0] ad, a, b; logic last;
        int op;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 9);
            a  = 3'($urandom_range(0, 7));
            b  = 3'($urandom_range(0, 7));
            wd = 8'($urandom_range(0, 255));
            if (op < 4) begin
                send_cmd(2'b01, a, b, wd, acc);
                model[a] = wd;
            end else if (op < 9) begin
                send_cmd(2'b00, a, b, wd, acc);
                get_rsp($urandom_range(0, 3), ok, da, db, ad, last, st, rc);
                n_chk++; if (!ok || da !== model[a] || db !== model[b] || ad !== a || last !== 1'b1 || !st)
                    $display("FAIL random_read it=%0d: got %h/%h@%0d last=%b stable=%b want %h/%h@%0d last=1 stable=1", it, da, db, ad, last, st, model[a], model[b], a); else n_pass++;
            end else begin
                send_cmd(2'b10, a, b, wd, acc);
                for (int k = 0; k < 8; k++) begin
                    get_rsp($urandom_range(0, 2), ok, da, db, ad, last, st, rc);
                    n_chk++; if (!ok || ad !== 3'(k) || da !== model[k] || db !== model[k] || last !== (k == 7) || !st)
                        $display("FAIL random_dump it=%0d k=%0d: got %h/%h@%0d last=%b want %h@%0d", it, k, da, db, ad, last, model[k], k); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_addr_a = 3'd0;
        bus.cmd_addr_b = 3'd0;
        bus.cmd_wdata  = 8'h00;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 8'(i + 1);

        test_reset();
        test_read_basic();
        test_dump(-1, 0, "dump");
        test_dump(3, 3, "dump_bp");
        test_write();
        test_reserved();
        test_reset_abort();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
